// File: rtl/varint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : varint_pkg
// Description : Shared definitions for the varint encoder/decoder pair:
//               default decoded width, encoded-length helper and the
//               decoder state type with its encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package varint_pkg;

  // Default width of a decoded value in bits.
  localparam int VARINT_DECODE_SIZE = 64;

  // Number of 7-bit groups needed to carry a value of the given width.
  function automatic int varint_max_bytes(input int decode_size);
    return (decode_size - 1) / 7 + 1;
  endfunction

  // Number of meaningful payload bits carried by the final group.
  function automatic int varint_last_bits(input int decode_size);
    return decode_size - 7 * (varint_max_bytes(decode_size) - 1);
  endfunction

  // Decoder state type and encodings.
  typedef logic [1:0] varint_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0; // waiting for the first byte
  localparam logic [1:0] ST_ACCUM = 2'd1; // gathering continuation bytes
  localparam logic [1:0] ST_HOLD  = 2'd2; // result presented, waiting on consumer
  localparam logic [1:0] ST_DRAIN = 2'd3; // overlong encoding, discarding tail

endpackage : varint_pkg
`default_nettype wire

// File: rtl/varint_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : varint_stream_decoder
// Description : Streaming LEB128-style varint decoder. Accepts one encoded
//               byte per cycle over a valid/ready handshake, accumulates the
//               7-bit payload groups little-endian and presents the decoded
//               value, its encoded length and an error flag over a second
//               valid/ready handshake, one cycle after the terminating byte.
// Ports       : clk        - clock, all state updates on rising edge
//               rst_n      - synchronous active-low reset
//               in_valid   - in_byte carries an encoded byte
//               in_ready   - decoder accepts in_byte this cycle
//               in_byte    - [7] continuation flag, [6:0] payload
//               out_valid  - a decode result is present
//               out_ready  - consumer takes the result
//               out_value  - decoded value (DECODE_SIZE bits)
//               out_size   - encoded length in bytes (1..MAX_BYTES)
//               out_error  - overlong or overflowing encoding
// Revision    : 1.0 - initial release
// ============================================================================
module varint_stream_decoder
  import varint_pkg::*;
#(
  parameter int DECODE_SIZE = VARINT_DECODE_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DECODE_SIZE-1:0] out_value,
  output logic [3:0]             out_size,
  output logic                   out_error
);

  localparam int MAX_BYTES = (DECODE_SIZE - 1) / 7 + 1;
  localparam int LAST_BITS = varint_last_bits(DECODE_SIZE);

  localparam logic [3:0] LAST_IDX = 4'(MAX_BYTES - 1);
  localparam logic [3:0] MAX_SIZE = 4'(MAX_BYTES);

  // out_size is only 4 bits wide, so longer encodings cannot be reported.
  if (MAX_BYTES > 15) begin : g_bad_max_bytes
    $error("varint_stream_decoder: MAX_BYTES exceeds 15, DECODE_SIZE too large");
  end

  varint_state_t          state;
  logic [DECODE_SIZE-1:0] acc;
  logic [3:0]             count;

  logic                   accept;
  logic                   cont;
  logic [6:0]             payload;
  logic                   at_last;
  logic [7:0]             shamt;
  logic [DECODE_SIZE-1:0] shifted;
  logic [DECODE_SIZE-1:0] merged;
  logic [7:0]             spill;
  logic                   overflow;

  assign in_ready  = rst_n && (state != ST_HOLD);
  assign out_valid = (state == ST_HOLD);

  assign accept  = in_valid && in_ready;
  assign cont    = in_byte[7];
  assign payload = in_byte[6:0];
  assign at_last = (count == LAST_IDX);

  // Group k lands at bits [7k+6:7k]; anything shifted past the top of the
  // value falls off the end of the vector and is discarded.
  assign shamt   = 8'(count) * 8'd7;
  assign shifted = DECODE_SIZE'(payload) << shamt;
  assign merged  = acc | shifted;

  // Payload bits of the final group that sit at or above DECODE_SIZE.
  // With LAST_BITS == 7 the whole group fits and spill is always zero.
  assign spill    = {1'b0, payload} >> LAST_BITS;
  assign overflow = at_last && (spill != 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      count     <= 4'd0;
      out_value <= '0;
      out_size  <= 4'd0;
      out_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            acc <= merged;
            if (at_last && cont) begin
              // Overlong: freeze the error result now and swallow the rest
              // of the encoding so the stream resynchronises afterwards.
              out_value <= merged;
              out_size  <= MAX_SIZE;
              out_error <= 1'b1;
              state     <= ST_DRAIN;
            end else if (cont) begin
              count <= count + 4'd1;
              state <= ST_ACCUM;
            end else begin
              out_value <= merged;
              out_size  <= count + 4'd1;
              out_error <= overflow;
              state     <= ST_HOLD;
            end
          end
        end

        ST_DRAIN: begin
          if (accept && !cont) begin
            state <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            count <= 4'd0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : varint_stream_decoder
`default_nettype wire

// File: tb/tb_varint_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_varint_stream_decoder
// Description : Directed self-checking bench for varint_stream_decoder with
//               hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_varint_stream_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [3:0]  out_size;
  logic        out_error;

  int checks = 0;
  int errors = 0;

  varint_stream_decoder #(.DECODE_SIZE(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_size  (out_size),
    .out_error (out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte and wait (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_for_byte", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  // Check the presented result, then consume it.
  task automatic take(input string tag, input logic [63:0] v, input logic [3:0] s, input logic e);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_value"}, out_value, v);
    check({tag, "_size"},  64'(out_size), 64'(s));
    check({tag, "_error"}, 64'(out_error), 64'(e));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_value", out_value, 64'd0);
    check("rst_out_size", 64'(out_size), 64'd0);
    check("rst_out_error", 64'(out_error), 64'd0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Single byte 0x01: result appears one cycle after acceptance
    in_valid = 1'b1;
    in_byte  = 8'h01;
    check("one_not_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    take("one", 64'd1, 4'd1, 1'b0);

    // 0xAC 0x02 -> 300
    send_byte(8'hAC);
    send_byte(8'h02);
    take("v300", 64'd300, 4'd2, 1'b0);

    // Non-minimal zero
    send_byte(8'h80);
    send_byte(8'h00);
    take("nonmin", 64'd0, 4'd2, 1'b0);

    // Maximum value, 10 bytes
    for (int i = 0; i < 9; i++) send_byte(8'hFF);
    send_byte(8'h01);
    take("max", 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);

    // Overflow in the last group: value truncated, error flagged
    for (int i = 0; i < 9; i++) send_byte(8'hFF);
    send_byte(8'h03);
    take("ovf3", 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b1);

    // Overflow with only a high payload bit set in the last group
    send_byte(8'h85);
    for (int i = 0; i < 8; i++) send_byte(8'h80);
    send_byte(8'h02);
    take("ovf2", 64'd5, 4'd10, 1'b1);

    // Overlong: 0x80 x10, 0x80, 0x00 -> one error result, all 12 consumed
    for (int i = 0; i < 10; i++) send_byte(8'h80);
    check("drain_no_result", 64'(out_valid), 64'd0);
    send_byte(8'h80);
    check("drain_still_quiet", 64'(out_valid), 64'd0);
    send_byte(8'h00);
    take("overlong", 64'd0, 4'd10, 1'b1);

    // Back-pressure: 0x96 0x01 held for 5 cycles
    send_byte(8'h96);
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_value", out_value, 64'd150);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    take("bp", 64'd150, 4'd2, 1'b0);
    check("bp_ready_after_release", 64'(in_ready), 64'd1);
    send_byte(8'h07);
    take("bp_next", 64'd7, 4'd1, 1'b0);

    // Reset mid-accumulation abandons the partial result
    send_byte(8'hAC);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_no_out", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("midrst_still_no_out", 64'(out_valid), 64'd0);
    send_byte(8'h05);
    take("after_rst", 64'd5, 4'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_varint_stream_decoder
`default_nettype wire
